// File: rtl/ita_input_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : ita_input_writer_if
// Description : Stream-in / row-write bundle for the ITA input writer.
//               'slave' is the writer's view, 'master' is the view of the
//               environment that feeds beats and accepts row writes.
// Revision    : 1.0 - initial release
// ============================================================================
interface ita_input_writer_if #(
  parameter int N  = 16,
  parameter int WI = 8,
  parameter int E  = 64,
  parameter int S  = 64
);
  localparam int c_addr_w = (S > 1) ? $clog2(S) : 1;
  localparam int c_len_w  = $clog2(S + 1);
  localparam int c_emb_w  = $clog2(E + 1);

  // Transfer control and status
  logic                  start_i;
  logic [c_len_w-1:0]    seq_length_i;
  logic [c_emb_w-1:0]    embed_size_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  // Narrow input beat stream
  logic                  inp_valid_i;
  logic                  inp_ready_o;
  logic [N*WI-1:0]       inp_data_i;

  // Full-row write port toward the input memory
  logic                  wr_valid_o;
  logic                  wr_ready_i;
  logic [c_addr_w-1:0]   wr_addr_o;
  logic [E*WI-1:0]       wr_data_o;

  modport slave (
    input  start_i, seq_length_i, embed_size_i,
    input  inp_valid_i, inp_data_i, wr_ready_i,
    output inp_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
    output busy_o, done_o, err_o
  );

  modport master (
    output start_i, seq_length_i, embed_size_i,
    output inp_valid_i, inp_data_i, wr_ready_i,
    input  inp_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
    input  busy_o, done_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/ita_input_writer.sv
`default_nettype none
// ============================================================================
// Module      : ita_input_writer
// Description : Assembles N-byte input beats into E-byte token rows and
//               issues one row write per token, addresses 0..seq_length-1.
// Revision    : 1.0 - initial release
// ============================================================================
module ita_input_writer #(
  parameter int N  = 16,
  parameter int WI = 8,
  parameter int E  = 64,
  parameter int S  = 64
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  ita_input_writer_if.slave bus
);

  localparam int c_addr_w = (S > 1) ? $clog2(S) : 1;
  localparam int c_len_w  = $clog2(S + 1);
  localparam int c_emb_w  = $clog2(E + 1);
  localparam int c_beat_w = ((E / N) > 1) ? $clog2(E / N) : 1;
  localparam int c_beat_b = N * WI;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [E*WI-1:0]     r_buf;
  logic [c_beat_w-1:0] r_beat;
  logic [c_beat_w-1:0] r_last_beat;
  logic [c_addr_w-1:0] r_row;
  logic [c_addr_w-1:0] r_last_row;
  logic                r_inp_ready;
  logic                r_wr_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_cfg_ok;
  logic [c_beat_w-1:0] w_last_beat;
  logic [c_addr_w-1:0] w_last_row;

  // Config legality and the derived terminal counts latched at start
  always_comb begin
    w_cfg_ok    = (bus.seq_length_i != '0)
               && (bus.seq_length_i <= c_len_w'(S))
               && (bus.embed_size_i != '0)
               && (bus.embed_size_i <= c_emb_w'(E))
               && ((bus.embed_size_i % c_emb_w'(N)) == '0);
    w_last_beat = c_beat_w'((bus.embed_size_i / c_emb_w'(N)) - c_emb_w'(1));
    w_last_row  = c_addr_w'(bus.seq_length_i - c_len_w'(1));
  end

  // Transfer sequencer: fill a row from beats, write it, repeat per token
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_buf       <= '0;
      r_beat      <= '0;
      r_last_beat <= '0;
      r_row       <= '0;
      r_last_row  <= '0;
      r_inp_ready <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (w_cfg_ok) begin
              r_last_beat <= w_last_beat;
              r_last_row  <= w_last_row;
              r_buf       <= '0;
              r_beat      <= '0;
              r_row       <= '0;
              r_inp_ready <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ST_FILL;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (bus.inp_valid_i) begin
            r_buf[int'(r_beat) * c_beat_b +: c_beat_b] <= bus.inp_data_i;
            if (r_beat == r_last_beat) begin
              // Beat counter parks on the last beat; it is cleared per row
              r_inp_ready <= 1'b0;
              r_wr_valid  <= 1'b1;
              r_state     <= ST_WRITE;
            end else begin
              r_beat <= r_beat + c_beat_w'(1);
            end
          end
        end
        ST_WRITE: begin
          if (bus.wr_ready_i) begin
            r_wr_valid <= 1'b0;
            if (r_row == r_last_row) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_row       <= r_row + c_addr_w'(1);
              r_buf       <= '0;
              r_beat      <= '0;
              r_inp_ready <= 1'b1;
              r_state     <= ST_FILL;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_inp_ready <= 1'b0;
          r_wr_valid  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inp_ready_o = r_inp_ready;
  assign bus.wr_valid_o  = r_wr_valid;
  assign bus.wr_addr_o   = r_row;
  assign bus.wr_data_o   = r_buf;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;

endmodule
`default_nettype wire
